// File: rtl/object_reader_pkg.sv
// object_reader_pkg: shared label/location widths and types for the object reader slice
package object_reader_pkg;
  localparam int LBL_WIDTH = 8;
  localparam int LOC_SIZE  = 16;
  localparam int MAX_LABEL = 1 << LBL_WIDTH;
  typedef logic [LBL_WIDTH-1:0] lbl_t;
  typedef logic [LOC_SIZE-1:0]  loc_t;
endpackage

// File: rtl/object_reader_if.sv
// object_reader_if: valid/ready record stream (id, area, centroid x/y)
// master: drives valid/id/area/cx/cy, samples ready; slave: the reverse
interface object_reader_if;
  import object_reader_pkg::*;
  logic valid;
  logic ready;
  lbl_t id;
  loc_t area;
  loc_t cx;
  loc_t cy;
  modport master (output valid, id, area, cx, cy, input ready);
  modport slave  (input valid, id, area, cx, cy, output ready);
endinterface

// File: rtl/object_reader_divider.sv
// seq_divider: restoring unsigned divider, one quotient bit per cycle, W cycles per divide
// ports: clk, reset_n (sync, active-low), i_start (load operands), i_dividend, i_divisor,
//        o_quotient (valid while o_done is high), o_done (one-cycle completion pulse)
module seq_divider
  import object_reader_pkg::*;
#(
  parameter int W = LOC_SIZE
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_start,
  input  logic [W-1:0] i_dividend,
  input  logic [W-1:0] i_divisor,
  output logic [W-1:0] o_quotient,
  output logic         o_done
);
  localparam int CW = $clog2(W + 1);
  logic [W-1:0]  r_rem;
  logic [W-1:0]  r_quo;
  logic [W-1:0]  r_dvs;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;
  logic [W:0]    w_shift;
  logic          w_ge;
  // partial remainder stays below the divisor, so W bits hold it; the shifted value needs W+1
  assign w_shift    = {r_rem, r_quo[W-1]};
  assign w_ge       = w_shift >= {1'b0, r_dvs};
  assign o_quotient = r_quo;
  assign o_done     = r_done;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_rem  <= '0;
        r_quo  <= i_dividend;
        r_dvs  <= i_divisor;
        r_cnt  <= CW'(W);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_rem <= w_ge ? W'(w_shift - {1'b0, r_dvs}) : w_shift[W-1:0];
        r_quo <= {r_quo[W-2:0], w_ge};
        r_cnt <= r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/object_reader.sv
// object_reader: sweeps labeler object tables, emits (id, area, centroid) records
// ports: clk, reset_n (sync, active-low), i_start (sweep request), i_num_labels (next free label),
//        o_obj_id / i_obj_area / i_obj_x / i_obj_y (object table read port, READ_LAT latency),
//        rec_if (record stream master), o_busy, o_done (end-of-sweep pulse), o_obj_count
module object_reader
  import object_reader_pkg::*;
#(
  parameter int MIN_AREA = 1,
  parameter int READ_LAT = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_start,
  input  lbl_t                   i_num_labels,
  output lbl_t                   o_obj_id,
  input  loc_t                   i_obj_area,
  input  loc_t                   i_obj_x,
  input  loc_t                   i_obj_y,
  object_reader_if.master        rec_if,
  output logic                   o_busy,
  output logic                   o_done,
  output lbl_t                   o_obj_count
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_DIV     = 3'd4;
  localparam logic [2:0] S_EMIT    = 3'd5;
  localparam logic [2:0] S_FINISH  = 3'd6;
  localparam int         IW        = LBL_WIDTH + 1;
  localparam loc_t       MIN_A     = loc_t'(MIN_AREA);
  localparam logic [7:0] WAIT_LAST = 8'(READ_LAT - 1);
  logic [2:0]    r_state;
  // one extra bit so the id counter can step past the last label without wrapping
  logic [IW-1:0] r_id;
  lbl_t          r_num;
  lbl_t          r_obj_id;
  lbl_t          r_count;
  logic [7:0]    r_wait;
  loc_t          r_area;
  loc_t          r_x;
  loc_t          r_y;
  loc_t          r_last_area;
  loc_t          r_last_x;
  loc_t          r_last_y;
  loc_t          r_cx;
  logic          r_phase;
  logic          r_valid;
  lbl_t          r_rec_id;
  loc_t          r_rec_area;
  loc_t          r_rec_cx;
  loc_t          r_rec_cy;
  logic          w_skip;
  logic          w_issue_end;
  logic          w_div_start;
  loc_t          w_dividend;
  loc_t          w_divisor;
  loc_t          w_quot;
  logic          w_qdone;
  // equal area/x/y to the previous record means two labels resolved to the same root
  assign w_skip      = (i_obj_area < MIN_A) || (i_obj_area == '0) ||
                       ({i_obj_area, i_obj_x, i_obj_y} == {r_last_area, r_last_x, r_last_y});
  assign w_issue_end = (r_id >= {1'b0, r_num}) || r_id[LBL_WIDTH];
  // x divide starts straight from the read port; y divide starts as the x result lands
  assign w_div_start = (r_state == S_CAPTURE && !w_skip) || (r_state == S_DIV && w_qdone && !r_phase);
  assign w_dividend  = r_state == S_CAPTURE ? i_obj_x : r_y;
  assign w_divisor   = r_state == S_CAPTURE ? i_obj_area : r_area;
  seq_divider #(.W(LOC_SIZE)) u_div (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_start    (w_div_start),
    .i_dividend (w_dividend),
    .i_divisor  (w_divisor),
    .o_quotient (w_quot),
    .o_done     (w_qdone)
  );
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_id        <= '0;
      r_num       <= '0;
      r_obj_id    <= '0;
      r_count     <= '0;
      r_wait      <= '0;
      r_area      <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_last_area <= '0;
      r_last_x    <= '0;
      r_last_y    <= '0;
      r_cx        <= '0;
      r_phase     <= 1'b0;
      r_valid     <= 1'b0;
      r_rec_id    <= '0;
      r_rec_area  <= '0;
      r_rec_cx    <= '0;
      r_rec_cy    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_obj_id <= '0;
          if (i_start) begin
            r_id        <= IW'(1);
            r_count     <= '0;
            r_num       <= i_num_labels;
            r_last_area <= '0;
            r_last_x    <= '0;
            r_last_y    <= '0;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_issue_end) r_state <= S_FINISH;
          else begin
            r_obj_id <= r_id[LBL_WIDTH-1:0];
            r_wait   <= '0;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_wait <= r_wait + 8'd1;
          if (r_wait == WAIT_LAST) r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          r_area <= i_obj_area;
          r_x    <= i_obj_x;
          r_y    <= i_obj_y;
          if (w_skip) begin
            r_id    <= r_id + IW'(1);
            r_state <= S_ISSUE;
          end else begin
            r_phase <= 1'b0;
            r_state <= S_DIV;
          end
        end
        S_DIV: begin
          if (w_qdone && !r_phase) begin
            r_cx    <= w_quot;
            r_phase <= 1'b1;
          end else if (w_qdone) begin
            r_rec_id   <= r_obj_id;
            r_rec_area <= r_area;
            r_rec_cx   <= r_cx;
            r_rec_cy   <= w_quot;
            r_valid    <= 1'b1;
            r_state    <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (rec_if.ready) begin
            r_valid     <= 1'b0;
            r_count     <= r_count + lbl_t'(1);
            r_id        <= r_id + IW'(1);
            r_last_area <= r_area;
            r_last_x    <= r_x;
            r_last_y    <= r_y;
            r_state     <= S_ISSUE;
          end
        end
        S_FINISH: begin
          r_obj_id <= '0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign rec_if.valid = r_valid;
  assign rec_if.id    = r_rec_id;
  assign rec_if.area  = r_rec_area;
  assign rec_if.cx    = r_rec_cx;
  assign rec_if.cy    = r_rec_cy;
  assign o_obj_id     = r_obj_id;
  assign o_busy       = r_state != S_IDLE;
  assign o_done       = r_state == S_FINISH;
  assign o_obj_count  = r_count;
endmodule

// File: tb/tb_object_reader.sv
// tb_object_reader: directed checks of object_reader (default MIN_AREA and MIN_AREA=3 instances)
module tb_object_reader;
  import object_reader_pkg::*;
  localparam int RL = 2;
  typedef struct packed {lbl_t id; loc_t area; loc_t cx; loc_t cy;} rec_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic ready = 1'b1;
  lbl_t num_labels = '0;
  lbl_t a_id, b_id, a_cnt, b_cnt;
  loc_t a_area, a_x, a_y, b_area, b_x, b_y;
  logic a_busy, a_done, b_busy, b_done;
  loc_t m_area [MAX_LABEL];
  loc_t m_x [MAX_LABEL];
  loc_t m_y [MAX_LABEL];
  logic [47:0] pa [RL];
  logic [47:0] pb [RL];
  rec_t qa[$];
  rec_t qb[$];
  int done_a = 0;
  int valid_a = 0;
  int n_cmp = 0;
  int n_fail = 0;
  object_reader_if ra();
  object_reader_if rb();
  assign ra.ready = ready;
  assign rb.ready = ready;
  object_reader #(.MIN_AREA(1), .READ_LAT(RL)) dut_a (
    .clk(clk), .reset_n(reset_n), .i_start(start), .i_num_labels(num_labels),
    .o_obj_id(a_id), .i_obj_area(a_area), .i_obj_x(a_x), .i_obj_y(a_y),
    .rec_if(ra), .o_busy(a_busy), .o_done(a_done), .o_obj_count(a_cnt));
  object_reader #(.MIN_AREA(3), .READ_LAT(RL)) dut_b (
    .clk(clk), .reset_n(reset_n), .i_start(start), .i_num_labels(num_labels),
    .o_obj_id(b_id), .i_obj_area(b_area), .i_obj_x(b_x), .i_obj_y(b_y),
    .rec_if(rb), .o_busy(b_busy), .o_done(b_done), .o_obj_count(b_cnt));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    pa[0] <= {m_area[a_id], m_x[a_id], m_y[a_id]};
    for (int i = 1; i < RL; i++) pa[i] <= pa[i-1];
  end
  always @(posedge clk) begin
    pb[0] <= {m_area[b_id], m_x[b_id], m_y[b_id]};
    for (int j = 1; j < RL; j++) pb[j] <= pb[j-1];
  end
  assign {a_area, a_x, a_y} = pa[RL-1];
  assign {b_area, b_x, b_y} = pb[RL-1];
  always @(posedge clk) begin
    if (ra.valid && ra.ready) qa.push_back(rec_t'({ra.id, ra.area, ra.cx, ra.cy}));
    if (rb.valid && rb.ready) qb.push_back(rec_t'({rb.id, rb.area, rb.cx, rb.cy}));
    if (a_done) done_a <= done_a + 1;
    if (ra.valid) valid_a <= valid_a + 1;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic set_obj(input int id, input int ar, input int x, input int y);
    m_area[id] = loc_t'(ar);
    m_x[id] = loc_t'(x);
    m_y[id] = loc_t'(y);
  endtask
  task automatic pulse_start(input int n);
    @(negedge clk);
    num_labels = lbl_t'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_idle(input string tag);
    int c = 0;
    while ((a_busy || b_busy) && c < 2000) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_timeout"}, 64'(a_busy || b_busy), 64'd0);
  endtask
  task automatic wait_valid(input string tag);
    int c = 0;
    while (!ra.valid && c < 300) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_valid_seen"}, 64'(ra.valid), 64'd1);
  endtask
  initial begin
    int base, bbase, bv, bd, c;
    for (int k = 0; k < MAX_LABEL; k++) set_obj(k, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("reset_state", 64'({a_busy, a_done, ra.valid, a_id, a_cnt, ra.id, ra.area, ra.cx, ra.cy}), 64'd0);
    reset_n = 1'b1;
    bv = valid_a;
    bd = done_a;
    pulse_start(1);
    c = 1;
    while (!a_done && c < 10) begin
      @(negedge clk);
      c++;
    end
    chk("n1_done_latency", 64'(a_done && c <= 3), 64'd1);
    wait_idle("n1");
    chk("n1_no_valid", 64'(valid_a - bv), 64'd0);
    chk("n1_count", 64'(a_cnt), 64'd0);
    chk("n1_single_done", 64'(done_a - bd), 64'd1);
    chk("n1_obj_id_idle", 64'(a_id), 64'd0);
    set_obj(1, 4, 20, 8);
    set_obj(2, 2, 6, 10);
    base = qa.size();
    bbase = qb.size();
    pulse_start(3);
    wait_idle("basic");
    chk("basic_nrec", 64'(qa.size() - base), 64'd2);
    chk("basic_rec1", 64'(qa[base]), 64'({8'd1, 16'd4, 16'd5, 16'd2}));
    chk("basic_rec2", 64'(qa[base+1]), 64'({8'd2, 16'd2, 16'd3, 16'd5}));
    chk("basic_count", 64'(a_cnt), 64'd2);
    chk("basic_min3_nrec", 64'(qb.size() - bbase), 64'd1);
    set_obj(1, 2, 6, 4);
    set_obj(2, 0, 0, 0);
    set_obj(3, 6, 12, 18);
    base = qa.size();
    bbase = qb.size();
    pulse_start(4);
    wait_idle("minarea");
    chk("zero_nrec", 64'(qa.size() - base), 64'd2);
    chk("zero_rec1", 64'(qa[base]), 64'({8'd1, 16'd2, 16'd3, 16'd2}));
    chk("zero_rec2", 64'(qa[base+1]), 64'({8'd3, 16'd6, 16'd2, 16'd3}));
    chk("min3_nrec", 64'(qb.size() - bbase), 64'd1);
    chk("min3_rec", 64'(qb[bbase]), 64'({8'd3, 16'd6, 16'd2, 16'd3}));
    chk("min3_count", 64'(b_cnt), 64'd1);
    set_obj(1, 4, 20, 8);
    set_obj(2, 4, 20, 8);
    base = qa.size();
    pulse_start(3);
    wait_idle("dup");
    chk("dup_nrec", 64'(qa.size() - base), 64'd1);
    chk("dup_rec", 64'(qa[base]), 64'({8'd1, 16'd4, 16'd5, 16'd2}));
    chk("dup_count", 64'(a_cnt), 64'd1);
    set_obj(1, 3, 9, 6);
    ready = 1'b0;
    base = qa.size();
    pulse_start(2);
    wait_valid("stall");
    for (int k = 0; k < 10; k++) begin
      chk("stall_hold", 64'({ra.valid, ra.id, ra.area, ra.cx, ra.cy}), 64'({1'b1, 8'd1, 16'd3, 16'd3, 16'd2}));
      @(negedge clk);
    end
    chk("stall_no_handshake", 64'(qa.size() - base), 64'd0);
    ready = 1'b1;
    wait_idle("stall");
    chk("stall_one_handshake", 64'(qa.size() - base), 64'd1);
    chk("stall_count", 64'(a_cnt), 64'd1);
    set_obj(1, 4, 20, 8);
    set_obj(2, 2, 6, 10);
    pulse_start(3);
    repeat (8) @(negedge clk);
    chk("div_in_progress", 64'({a_busy, ra.valid}), 64'b10);
    reset_n = 1'b0;
    @(negedge clk);
    chk("div_reset", 64'({a_busy, ra.valid, a_id, a_cnt}), 64'd0);
    reset_n = 1'b1;
    ready = 1'b0;
    pulse_start(3);
    wait_valid("emit");
    reset_n = 1'b0;
    @(negedge clk);
    chk("emit_reset", 64'({a_busy, ra.valid, a_done, a_cnt}), 64'd0);
    reset_n = 1'b1;
    ready = 1'b1;
    base = qa.size();
    pulse_start(3);
    wait_idle("resweep");
    chk("resweep_nrec", 64'(qa.size() - base), 64'd2);
    chk("resweep_rec1", 64'(qa[base]), 64'({8'd1, 16'd4, 16'd5, 16'd2}));
    chk("resweep_rec2", 64'(qa[base+1]), 64'({8'd2, 16'd2, 16'd3, 16'd5}));
    chk("resweep_count", 64'(a_cnt), 64'd2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/object_reader.md
OBJECT_READER -- requirements
Module: object_reader

Interface
REQ-001 Parameter MIN_AREA, default 1: minimum accumulated area for an object to be reported.
REQ-002 Parameter READ_LAT, default 2: cycles from obj_id change to valid obj_area/obj_x/obj_y.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 start  input  1  single-cycle pulse requesting a sweep of the object tables.
REQ-006 num_labels  input  LBL_WIDTH  next unallocated label; valid ids are 1..num_labels-1.
REQ-007 obj_id  output  LBL_WIDTH  object id presented to the labeler's object read port.
REQ-008 obj_area  input  LOC_SIZE  pixel count for obj_id, READ_LAT cycles after obj_id.
REQ-009 obj_x  input  LOC_SIZE  sum of x over object pixels, same timing as obj_area.
REQ-010 obj_y  input  LOC_SIZE  sum of y over object pixels, same timing as obj_area.
REQ-011 rec_valid  output  1  object record available.
REQ-012 rec_ready  input  1  downstream accepts record.
REQ-013 rec_id, rec_area, rec_cx, rec_cy  output  LBL_WIDTH/LOC_SIZE/LOC_SIZE/LOC_SIZE  record fields.
REQ-014 busy  output  1  sweep in progress; done  output  1  one-cycle end-of-sweep pulse.
REQ-015 obj_count  output  LBL_WIDTH  records emitted in the current/last sweep.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT, CAPTURE, DIV, EMIT, FINISH.
REQ-017 IDLE->ISSUE on start; start SHALL be ignored outside IDLE.
REQ-018 On entering ISSUE from IDLE, id counter SHALL load 1 and obj_count SHALL clear to 0; num_labels SHALL be latched.
REQ-019 ISSUE SHALL go to FINISH when id >= latched num_labels (including num_labels <= 1), else drive obj_id=id and go to WAIT.
REQ-020 WAIT SHALL hold obj_id stable for exactly READ_LAT cycles, then CAPTURE registers area/x/y.
REQ-021 CAPTURE SHALL skip the object (id+1, back to ISSUE) if area < MIN_AREA or area == 0.
REQ-022 CAPTURE SHALL skip when (area, x, y) equals the last emitted record (duplicate resolving to same root).
REQ-023 Otherwise DIV SHALL compute cx = floor(x/area) then cy = floor(y/area) using the shared sequential divider, LOC_SIZE cycles each, LOC_SIZE+? no early exit.
REQ-024 EMIT SHALL assert rec_valid with fields stable until the cycle rec_valid & rec_ready; then obj_count+1, id+1, to ISSUE.
REQ-025 rec_valid SHALL NOT deassert without a handshake; rec_ready while rec_valid=0 SHALL have no effect.
REQ-026 FINISH SHALL pulse done for one cycle and return to IDLE; busy SHALL be 1 in all states except IDLE.
REQ-027 obj_id SHALL be 0 in IDLE; obj_count SHALL hold its value after FINISH until next start.
REQ-028 Id counter SHALL not wrap: max id is MAX_LABEL-1, after which ISSUE goes to FINISH.

Reset
REQ-029 reset_n low at any clock edge SHALL force IDLE, abort any divide, and clear rec_valid, busy, done, obj_id, obj_count, rec_* and last-record registers to 0.
REQ-030 Reset mid-EMIT SHALL drop the pending record with no handshake required.

Structure
REQ-031 LBL_WIDTH, LOC_SIZE, MAX_LABEL SHALL come from the shared global header; FSM state encodings local.
REQ-032 Division SHALL live in sub-module seq_divider (start, dividend, divisor, quotient, done; restoring, one bit/cycle).

Verification
REQ-033 num_labels=1, start -> done pulse within 3 cycles, rec_valid never high, obj_count=0.
REQ-034 num_labels=3, id1 area=4 x=20 y=8, id2 area=2 x=6 y=10, rec_ready=1 -> records (1,4,5,2),(2,2,3,5), obj_count=2, then done.
REQ-035 MIN_AREA=3, id1 area=2 -> no record for id1; id2 area=0 -> skipped, no divide hang.
REQ-036 id2 returns same area/x/y as id1 -> only id1 emitted.
REQ-037 rec_ready held low 10 cycles during EMIT -> rec_valid and fields stable all 10 cycles, single handshake.
REQ-038 reset_n low during DIV and during EMIT -> next cycle busy=0, rec_valid=0; new start performs full sweep correctly.
